xbar_switch: RTL and testbench

Parameterised N-input, M-output data crossbar: every output independently selects any one input word through its own select field. It is a generic datapath primitive used wherever several producers fan out to several consumers, for example register-file read ports and issue/forwarding paths. The default configuration is purely combinational. An optional output register stage can be enabled for timing closure.

---
 rtl/xbar_switch_pkg.sv | 13 +
 rtl/xbar_mux.sv | 32 +++
 rtl/xbar_switch.sv | 67 ++++++
 tb/tb_xbar_switch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_switch_pkg.sv
// xbar_switch_pkg
//   Shared helpers for the crossbar. The crossbar and its mux both size their
//   select fields with sel_width(), so the two files cannot disagree.
//   Ports: none (package).
package xbar_switch_pkg;

   // Select field width for an n-input mux. A 1-input mux still gets a
   // 1-bit select so the port never collapses to zero width.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : xbar_switch_pkg

// File: rtl/xbar_mux.sv
// xbar_mux
//   NUM_INPUT:1 word mux. A select value at or above NUM_INPUT produces an
//   all-zero word.
//   Ports:
//     data  [NUM_INPUT-1:0][DATA_WIDTH-1:0]  candidate words, index = input number
//     sel   [SEL_W-1:0]                      index of the word to pass through
//     word  [DATA_WIDTH-1:0]                 selected word, or zero when sel is out of range
module xbar_mux
   import xbar_switch_pkg::*;
#(
   parameter  int NUM_INPUT  = 4,
   parameter  int DATA_WIDTH = 4,
   localparam int SEL_W      = sel_width(NUM_INPUT)
) (
   input  logic [NUM_INPUT-1:0][DATA_WIDTH-1:0] data,
   input  logic [SEL_W-1:0]                     sel,
   output logic [DATA_WIDTH-1:0]                word
);

   // Each input is gated by an equality match on sel, so an unselected
   // input (even one carrying X/Z) never reaches the output. When no index
   // matches, the zero default is kept.
   always_comb begin
      word = '0;
      for (int i = 0; i < NUM_INPUT; i++) begin
         if (sel == SEL_W'(i)) begin
            word = data[i];
         end
      end
   end

endmodule : xbar_mux

// File: rtl/xbar_switch.sv
// xbar_switch
//   N-input, M-output data crossbar. Every output independently picks one
//   input word through its own select field. Broadcast is allowed, and
//   unselected inputs are dropped. With REG_OUTPUT=0 the block is purely
//   combinational. With REG_OUTPUT=1 each output word is registered on
//   clk_i and is cleared by a synchronous, active-high rst_i.
//   Ports:
//     clk_i            clock (registered mode only)
//     rst_i            synchronous active-high reset (registered mode only)
//     input_vector_i   [NUM_INPUT-1:0][DATA_WIDTH-1:0]   input words
//     select_vector_i  [NUM_OUTPUT-1:0][SEL_W-1:0]       per-output source index
//     output_vector_o  [NUM_OUTPUT-1:0][DATA_WIDTH-1:0]  output words
module xbar_switch
   import xbar_switch_pkg::*;
#(
   parameter  int NUM_INPUT  = 4,
   parameter  int NUM_OUTPUT = 4,
   parameter  int DATA_WIDTH = 4,
   parameter  int REG_OUTPUT = 0,
   localparam int SEL_W      = sel_width(NUM_INPUT)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NUM_INPUT-1:0][DATA_WIDTH-1:0]  input_vector_i,
   input  logic [NUM_OUTPUT-1:0][SEL_W-1:0]      select_vector_i,
   output logic [NUM_OUTPUT-1:0][DATA_WIDTH-1:0] output_vector_o
);

   for (genvar j = 0; j < NUM_OUTPUT; j++) begin : g_out
      logic [DATA_WIDTH-1:0] word;

      xbar_mux #(
         .NUM_INPUT  (NUM_INPUT),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_mux (
         .data (input_vector_i),
         .sel  (select_vector_i[j]),
         .word (word)
      );

      if (REG_OUTPUT != 0) begin : g_reg
         logic [DATA_WIDTH-1:0] word_q;

         // Reset wins over the in-flight word, so the first value after
         // reset comes from the first edge that sees rst_i low.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               word_q <= '0;
            end else begin
               word_q <= word;
            end
         end

         assign output_vector_o[j] = word_q;
      end else begin : g_comb
         assign output_vector_o[j] = word;
      end
   end

   // In combinational mode clock and reset have no function. They are folded
   // into a deliberately unused net so they still count as read.
   if (REG_OUTPUT == 0) begin : g_no_clock
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_i;
   end

endmodule : xbar_switch

// File: tb/tb_xbar_switch.sv
// tb_xbar_switch
//   Bench for xbar_switch. Three instances share one stimulus set:
//   the default combinational build, a 3-input combinational build (for
//   out-of-range selects), and a registered build.
//   Ports: none (top-level bench).
module tb_xbar_switch;

   logic             clk;
   logic             rst;
   logic [3:0][3:0]  in_vec;
   logic [3:0][1:0]  sel_vec;
   logic [2:0][3:0]  in3;
   logic [3:0][1:0]  sel3;
   logic [3:0][3:0]  out_comb;
   logic [3:0][3:0]  out3;
   logic [3:0][3:0]  out_reg;

   // Stimulus at the level of the spec: plain words and integer selects.
   logic [3:0]       words[4];
   int               sels[4];

   int               passed;
   int               total;

   xbar_switch dut_comb (
      .clk_i           (clk),
      .rst_i           (rst),
      .input_vector_i  (in_vec),
      .select_vector_i (sel_vec),
      .output_vector_o (out_comb)
   );

   xbar_switch #(.NUM_INPUT(3)) dut_three (
      .clk_i           (clk),
      .rst_i           (rst),
      .input_vector_i  (in3),
      .select_vector_i (sel3),
      .output_vector_o (out3)
   );

   xbar_switch #(.REG_OUTPUT(1)) dut_reg (
      .clk_i           (clk),
      .rst_i           (rst),
      .input_vector_i  (in_vec),
      .select_vector_i (sel_vec),
      .output_vector_o (out_reg)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: output j carries word[sel j] when that input exists,
   // else zero.
   function automatic logic [3:0] model_word(input int j, input int n_in);
      int s;
      s = sels[j];
      if (s < n_in) return words[s];
      return 4'h0;
   endfunction

   // Driver: pack the stimulus arrays onto the DUT vectors.
   task automatic drive();
      for (int j = 0; j < 4; j++) begin
         in_vec[j]  = words[j];
         sel_vec[j] = 2'(sels[j]);
         sel3[j]    = 2'(sels[j]);
      end
      for (int j = 0; j < 3; j++) in3[j] = words[j];
   endtask

   task automatic set_identity_words();
      words[0] = 4'hA; words[1] = 4'hB; words[2] = 4'hC; words[3] = 4'hD;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_identity_words();
      for (int j = 0; j < 4; j++) sels[j] = j;
      drive();
      repeat (2) @(posedge clk);
      #1;
      for (int j = 0; j < 4; j++) begin
         total++;
         if (out_reg[j] !== 4'h0) $display("FAIL reset_reg[%0d] got %h want 0", j, out_reg[j]);
         else passed++;
         total++;
         if (out_comb[j] !== model_word(j, 4))
            $display("FAIL reset_comb[%0d] got %h want %h", j, out_comb[j], model_word(j, 4));
         else passed++;
      end
   endtask

   task automatic test_identity();
      @(negedge clk);
      rst = 1'b0;
      set_identity_words();
      for (int j = 0; j < 4; j++) sels[j] = j;
      drive();
      #1;
      for (int j = 0; j < 4; j++) begin
         total++;
         if (out_comb[j] !== model_word(j, 4))
            $display("FAIL identity_comb[%0d] got %h want %h", j, out_comb[j], model_word(j, 4));
         else passed++;
         total++;
         if (out_reg[j] !== 4'h0) $display("FAIL identity_reg_early[%0d] got %h want 0", j, out_reg[j]);
         else passed++;
      end
      @(posedge clk);
      #1;
      for (int j = 0; j < 4; j++) begin
         total++;
         if (out_reg[j] !== model_word(j, 4))
            $display("FAIL identity_reg[%0d] got %h want %h", j, out_reg[j], model_word(j, 4));
         else passed++;
      end
   endtask

   task automatic test_broadcast();
      @(negedge clk);
      for (int j = 0; j < 4; j++) sels[j] = 2;
      drive();
      #1;
      for (int j = 0; j < 4; j++) begin
         total++;
         if (out_comb[j] !== 4'hC) $display("FAIL broadcast_c[%0d] got %h want c", j, out_comb[j]);
         else passed++;
      end
      @(negedge clk);
      words[0] = 4'($urandom_range(0, 15));
      words[1] = 4'($urandom_range(0, 15));
      words[2] = 4'h5;
      words[3] = 4'($urandom_range(0, 15));
      drive();
      @(posedge clk);
      #1;
      for (int j = 0; j < 4; j++) begin
         total++;
         if (out_comb[j] !== 4'h5) $display("FAIL broadcast_5[%0d] got %h want 5", j, out_comb[j]);
         else passed++;
         total++;
         if (out_reg[j] !== 4'h5) $display("FAIL broadcast_reg[%0d] got %h want 5", j, out_reg[j]);
         else passed++;
      end
   endtask

   task automatic test_permutation();
      @(negedge clk);
      set_identity_words();
      for (int j = 0; j < 4; j++) sels[j] = j;
      drive();
      #1;
      // Only the selects change here, with no clock edge in between.
      for (int j = 0; j < 4; j++) sels[j] = 3 - j;
      drive();
      #1;
      total++;
      if (out_comb !== 16'hABCD) $display("FAIL permutation got %h want abcd", out_comb);
      else passed++;
   endtask

   task automatic test_out_of_range();
      @(negedge clk);
      set_identity_words();
      sels[0] = 3; sels[1] = 2; sels[2] = 0; sels[3] = 1;
      drive();
      #1;
      total++;
      if (out3[0] !== 4'h0) $display("FAIL oor_zero got %h want 0", out3[0]);
      else passed++;
      total++;
      if (out3[3:1] !== 12'hBAC) $display("FAIL oor_others got %h want bac", out3[3:1]);
      else passed++;
      total++;
      if (out_comb[0] !== 4'hD) $display("FAIL oor_full_width got %h want d", out_comb[0]);
      else passed++;
   endtask

   task automatic test_random();
      int per_ok[4];
      for (int j = 0; j < 4; j++) per_ok[j] = 0;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         for (int j = 0; j < 4; j++) begin
            words[j] = 4'($urandom_range(0, 15));
            sels[j]  = $urandom_range(0, 3);
         end
         drive();
         @(posedge clk);
         #1;
         for (int j = 0; j < 4; j++) begin
            total++;
            if (out_comb[j] !== model_word(j, 4)) begin
               $display("FAIL random_comb[%0d] cyc %0d got %h want %h", j, c, out_comb[j], model_word(j, 4));
            end else begin
               passed++;
               per_ok[j]++;
            end
            total++;
            if (out3[j] !== model_word(j, 3))
               $display("FAIL random_three[%0d] cyc %0d got %h want %h", j, c, out3[j], model_word(j, 3));
            else passed++;
            total++;
            if (out_reg[j] !== model_word(j, 4))
               $display("FAIL random_reg[%0d] cyc %0d got %h want %h", j, c, out_reg[j], model_word(j, 4));
            else passed++;
         end
      end
      for (int j = 0; j < 4; j++) begin
         total++;
         if (per_ok[j] < 100) $display("FAIL random_coverage[%0d] got %0d want >=100", j, per_ok[j]);
         else passed++;
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      set_identity_words();
      for (int j = 0; j < 4; j++) sels[j] = j;
      drive();
      @(posedge clk);
      #1;
      total++;
      if (out_reg !== 16'hDCBA) $display("FAIL midrst_pre got %h want dcba", out_reg);
      else passed++;
      @(negedge clk);
      rst = 1'b1;
      for (int j = 0; j < 4; j++) sels[j] = 3 - j;
      drive();
      @(posedge clk);
      #1;
      total++;
      if (out_reg !== 16'h0000) $display("FAIL midrst_clear got %h want 0", out_reg);
      else passed++;
      total++;
      if (out_comb !== 16'hABCD) $display("FAIL midrst_comb got %h want abcd", out_comb);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (out_reg !== 16'hABCD) $display("FAIL midrst_resume got %h want abcd", out_reg);
      else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst    = 1'b1;
      for (int j = 0; j < 4; j++) begin
         words[j] = 4'h0;
         sels[j]  = 0;
      end
      drive();
      test_reset();
      test_identity();
      test_broadcast();
      test_permutation();
      test_out_of_range();
      test_random();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_xbar_switch
